// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types and constants for the data-memory arbiter
package arbitro_pkg;

   localparam int BITS_DEFAULT  = 64;
   localparam int DEPTH_DEFAULT = 32;
   localparam int ADDR_W        = 5;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
      return (32'(addr) < depth);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-port round-robin winner select, purely combinational
module rr_arbiter2
   import arbitro_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic pointer,
   output logic winner,
   output logic grant_valid
);

   always_comb begin
      grant_valid = req0 | req1;
      winner      = PORT0;
      if (req0 && req1) begin
         winner = pointer;
      end else if (req1) begin
         winner = PORT1;
      end
   end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// rtl/arbitro_memoria_dados.sv - two-port round-robin arbiter in front of a single data memory
module arbitro_memoria_dados
   import arbitro_pkg::*;
#(
   parameter int BITS  = BITS_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [BITS-1:0]   wdata0,
   input  logic [BITS-1:0]   wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [BITS-1:0]   rdata,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [BITS-1:0]   mem_din,
   input  logic [BITS-1:0]   mem_dout
);

   state_t              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                owner_q, owner_d;
   logic                cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic [BITS-1:0]     cmd_wdata_q, cmd_wdata_d;
   logic [BITS-1:0]     rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                winner;
   logic                grant_valid;
   logic                cmd_in_range;

   rr_arbiter2 u_rr_arbiter2 (
      .req0        (req0),
      .req1        (req1),
      .pointer     (ptr_q),
      .winner      (winner),
      .grant_valid (grant_valid)
   );

   assign cmd_in_range = addr_in_range(cmd_addr_q, DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= PORT0;
         owner_q     <= PORT0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Command registers are only loaded on a grant, so input changes mid-access are ignored.
   always_comb begin
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      if (state_q == IDLE && grant_valid) begin
         owner_d     = winner;
         ptr_d       = ~ptr_q;
         cmd_we_d    = (winner == PORT1) ? we1    : we0;
         cmd_addr_d  = (winner == PORT1) ? addr1  : addr0;
         cmd_wdata_d = (winner == PORT1) ? wdata1 : wdata0;
      end else if (state_q == ACCESS) begin
         err_d   = ~cmd_in_range;
         rdata_d = (cmd_in_range && !cmd_we_q) ? mem_dout : '0;
      end
   end

   always_comb begin
      busy     = (state_q != IDLE);
      ack0     = (state_q == RESP) && (owner_q == PORT0);
      ack1     = (state_q == RESP) && (owner_q == PORT1);
      mem_we   = (state_q == ACCESS) && cmd_we_q && cmd_in_range;
      mem_addr = cmd_addr_q;
      mem_din  = cmd_wdata_q;
      rdata    = rdata_q;
      err      = err_q;
   end

endmodule

// File: doc/arbitro_memoria_dados.md
ARBITRO_MEMORIA_DADOS -- requirements
Module: arbitro_memoria_dados

Interface
REQ-001 SHALL have parameter BITS, default 64, data word width.
REQ-002 SHALL have parameter DEPTH, default 32, number of valid words; legal range 1..32.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  5  word address
- wdata0 / wdata1  in  BITS  write data
- ack0 / ack1  out  1  one-cycle completion pulse per port
- rdata  out  BITS  read data, valid while ack0 or ack1 is high
- err  out  1  address out of range, valid with ack
- busy  out  1  high whenever state is not IDLE
- mem_addr  out  5  data-memory address
- mem_we  out  1  data-memory write enable
- mem_din  out  BITS  data-memory write data
- mem_dout  in  BITS  data-memory combinational read data

Function
REQ-005 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one cycle in each of ACCESS and RESP.
REQ-006 In IDLE with any req high, SHALL select a winner, latch its we/addr/wdata into command registers, record the owner, and move to ACCESS; with no req, SHALL remain in IDLE.
REQ-007 Arbitration SHALL be round-robin with a 1-bit pointer: sole requester always wins; with both requesting, the port named by the pointer wins.
REQ-008 Pointer SHALL change to the other port after each grant, and only on a grant.
REQ-009 mem_addr and mem_din SHALL be driven from the command registers; mem_we SHALL be high only in ACCESS, when the latched command is a write and addr < DEPTH.
REQ-010 In ACCESS, a read SHALL register mem_dout into rdata; a write SHALL register 0 into rdata; out-of-range SHALL register 0 into rdata and set err.
REQ-011 In RESP, SHALL assert exactly one of ack0/ack1 (owner) for exactly one cycle; err and rdata SHALL hold until the next RESP.
REQ-012 Latency SHALL be: req sampled at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2; sustained throughput one access per 3 cycles.
REQ-013 Requests and commands SHALL be sampled only in IDLE; changes to req/we/addr/wdata in ACCESS or RESP SHALL NOT affect the ongoing access.
REQ-014 Deasserting req after grant SHALL NOT abort the access; the write still commits and ack is still issued.
REQ-015 A requester holding req high through ack SHALL be treated as a new request in the following IDLE cycle, subject to the pointer.
REQ-016 Out-of-range accesses (addr >= DEPTH) SHALL never assert mem_we.

Reset
REQ-017 On rst_n low, SHALL asynchronously force: state IDLE, pointer 0, ack0/ack1/err/busy 0, rdata 0, command registers 0 (mem_addr 0, mem_din 0, mem_we 0).
REQ-018 Reset asserted in ACCESS SHALL suppress mem_we immediately; no write commits and no ack is issued for that access.
REQ-019 First arbitration after reset release SHALL favour port 0 on a tie.

Structure
REQ-020 Shared package arbitro_pkg SHALL hold the FSM state type (IDLE, ACCESS, RESP), port-index constants, and BITS/DEPTH defaults.
REQ-021 SHALL instantiate one sub-module, rr_arbiter2: inputs req0, req1, pointer; outputs winner index and grant-valid; purely combinational.

Verification
REQ-022 Read: req0, addr0=6, mem_dout=51 -> ack0 two cycles later, rdata=51, err=0, mem_we never high.
REQ-023 Write then read: req1, we1=1, addr1=3, wdata1=0xAB -> mem_we high one cycle with mem_addr=3, mem_din=0xAB; ack1 2 cycles after req; a subsequent read of addr1=3 returns 0xAB.
REQ-024 Contention: req0 and req1 held high continuously from reset -> grant order 0,1,0,1; acks alternate every 3 cycles.
REQ-025 Range: DEPTH=16, read addr0=20 -> ack0 with err=1, rdata=0, mem_we=0.
REQ-026 Reset mid-write: rst_n low during ACCESS of a write to addr 5 -> mem_we drops immediately, no ack, memory word 5 unchanged, busy=0.
